// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet source: NUM_PKTS packets of PKT_LEN beats, counter payload from seed, tlast/SOF marking.
// Latency: first beat valid the cycle after start is sampled; done pulses one cycle after the final handshake.
// Backpressure: beat held stable while tvalid && !tready; optional LFSR bubbles with AXIS_PKTGEN_THROTTLE_EN.
module axis_pkt_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_CYCLES = 0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [LEN_WIDTH-1:0]    num_pkts,
    input  logic [DATA_WIDTH-1:0]   seed,
    input  logic [DEST_WIDTH-1:0]   dest,
    output logic                    busy,
    output logic                    done,
    output logic [LEN_WIDTH-1:0]    pkt_count,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  pkts_q;
    logic [LEN_WIDTH-1:0]  beat_idx;
    logic [LEN_WIDTH-1:0]  pkt_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic [GW-1:0]         gap_cnt;
    logic                  vld;
    logic                  xfer;
    logic                  last_beat;
    logic                  final_pkt;

    assign xfer      = vld && m_axis_tready;
    assign last_beat = (beat_idx == len_q - LEN_WIDTH'(1));
    assign final_pkt = (pkt_cnt_q == pkts_q - LEN_WIDTH'(1));

`ifdef AXIS_PKTGEN_THROTTLE_EN
    logic [15:0] lfsr;
    logic        vld_hold;

    // x^16+x^14+x^13+x^11+1; vld_hold keeps an offered beat up until it is taken
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lfsr     <= 16'hACE1;
            vld_hold <= 1'b0;
        end else begin
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            vld_hold <= vld && !m_axis_tready;
        end
    end

    assign vld = (state == SEND) && (vld_hold || !lfsr[0]);
`else
    assign vld = (state == SEND);
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_pkts == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (xfer && last_beat) begin
                    if (final_pkt) begin
                        state_nxt = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = SEND;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                    state_nxt = SEND;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_q     <= '0;
            pkts_q    <= '0;
            beat_idx  <= '0;
            pkt_cnt_q <= '0;
            data_q    <= '0;
            dest_q    <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        // zero-length request still produces one beat per packet
                        len_q     <= (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
                        pkts_q    <= num_pkts;
                        data_q    <= seed;
                        dest_q    <= dest;
                        beat_idx  <= '0;
                        pkt_cnt_q <= '0;
                        gap_cnt   <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        data_q <= data_q + DATA_WIDTH'(1);
                        if (last_beat) begin
                            beat_idx  <= '0;
                            pkt_cnt_q <= pkt_cnt_q + LEN_WIDTH'(1);
                            gap_cnt   <= '0;
                        end else begin
                            beat_idx <= beat_idx + LEN_WIDTH'(1);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy          = (state == SEND) || (state == GAP);
    assign done          = (state == DONE);
    assign pkt_count     = pkt_cnt_q;
    assign m_axis_tvalid = vld;
    assign m_axis_tdata  = data_q;
    assign m_axis_tstrb  = '1;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = (state == SEND) && last_beat;
    assign m_axis_tid    = 1'b0;
    assign m_axis_tdest  = dest_q;

    always_comb begin
        m_axis_tuser    = '0;
        m_axis_tuser[0] = (state == SEND) && (beat_idx == '0);
    end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Directed bench for axis_pkt_gen built with GAP_CYCLES=2.
module tb_axis_pkt_gen;

    logic        aclk;
    logic        aresetn;
    logic        start;
    logic [15:0] pkt_len;
    logic [15:0] num_pkts;
    logic [31:0] seed;
    logic [3:0]  dest;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tid;
    logic [3:0]  tdest;
    logic [0:0]  tuser;

    int checks   = 0;
    int failures = 0;

    axis_pkt_gen #(
        .DATA_WIDTH(32),
        .DEST_WIDTH(4),
        .USER_WIDTH(1),
        .LEN_WIDTH (16),
        .GAP_CYCLES(2)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .start        (start),
        .pkt_len      (pkt_len),
        .num_pkts     (num_pkts),
        .seed         (seed),
        .dest         (dest),
        .busy         (busy),
        .done         (done),
        .pkt_count    (pkt_count),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tdata (tdata),
        .m_axis_tstrb (tstrb),
        .m_axis_tkeep (tkeep),
        .m_axis_tlast (tlast),
        .m_axis_tid   (tid),
        .m_axis_tdest (tdest),
        .m_axis_tuser (tuser)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // check the currently presented beat, then advance one clock
    task automatic beat(input string tag, input logic [31:0] d, input logic last, input logic sof);
        chk({tag, "_vld"}, 64'(tvalid), 64'(1));
        chk({tag, "_dat"}, 64'(tdata), 64'(d));
        chk({tag, "_last"}, 64'(tlast), 64'(last));
        chk({tag, "_sof"}, 64'(tuser[0]), 64'(sof));
        step();
    endtask

    task automatic idle_chk(input string tag, input logic exp_busy);
        chk({tag, "_vld"}, 64'(tvalid), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
        step();
    endtask

    task automatic done_chk(input string tag, input logic [15:0] cnt);
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_vld"}, 64'(tvalid), 64'(0));
        chk({tag, "_cnt"}, 64'(pkt_count), 64'(cnt));
        step();
        chk({tag, "_done_clr"}, 64'(done), 64'(0));
    endtask

    task automatic go(input logic [31:0] s, input logic [15:0] len, input logic [15:0] n);
        seed     = s;
        pkt_len  = len;
        num_pkts = n;
        start    = 1'b1;
        step();
        start    = 1'b0;
        seed     = 32'hDEAD_BEEF;
        pkt_len  = 16'd9;
        num_pkts = 16'd7;
    endtask

    initial begin
        aresetn  = 1'b0;
        start    = 1'b0;
        pkt_len  = '0;
        num_pkts = '0;
        seed     = '0;
        dest     = 4'h5;
        tready   = 1'b1;
        repeat (2) step();

        chk("rst_vld", 64'(tvalid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_dat", 64'(tdata), 64'(0));
        chk("rst_cnt", 64'(pkt_count), 64'(0));
        chk("rst_last", 64'(tlast), 64'(0));
        chk("rst_user", 64'(tuser), 64'(0));
        chk("rst_dest", 64'(tdest), 64'(0));
        chk("const_strb", 64'(tstrb), 64'(4'hF));
        chk("const_keep", 64'(tkeep), 64'(4'hF));
        chk("const_tid", 64'(tid), 64'(0));
        aresetn = 1'b1;
        step();

        // single packet, full rate
        go(32'h10, 16'd4, 16'd1);
        dest = 4'h9;
        chk("p1_busy", 64'(busy), 64'(1));
        chk("p1_dest", 64'(tdest), 64'(5));
        beat("p1_b0", 32'h10, 1'b0, 1'b1);
        beat("p1_b1", 32'h11, 1'b0, 1'b0);
        beat("p1_b2", 32'h12, 1'b0, 1'b0);
        beat("p1_b3", 32'h13, 1'b1, 1'b0);
        done_chk("p1", 16'd1);

        // two packets with a two-cycle gap
        go(32'h100, 16'd3, 16'd2);
        beat("g_b0", 32'h100, 1'b0, 1'b1);
        beat("g_b1", 32'h101, 1'b0, 1'b0);
        beat("g_b2", 32'h102, 1'b1, 1'b0);
        chk("g_gap_cnt", 64'(pkt_count), 64'(1));
        idle_chk("g_gap0", 1'b1);
        idle_chk("g_gap1", 1'b1);
        beat("g_b3", 32'h103, 1'b0, 1'b1);
        beat("g_b4", 32'h104, 1'b0, 1'b0);
        beat("g_b5", 32'h105, 1'b1, 1'b0);
        done_chk("g", 16'd2);

        // backpressure mid-packet, with a start attempt while busy
        go(32'h20, 16'd4, 16'd1);
        beat("bp_b0", 32'h20, 1'b0, 1'b1);
        tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            seed  = 32'h777;
            beat($sformatf("bp_hold%0d", i), 32'h21, 1'b0, 1'b0);
        end
        start  = 1'b0;
        tready = 1'b1;
        beat("bp_b1", 32'h21, 1'b0, 1'b0);
        beat("bp_b2", 32'h22, 1'b0, 1'b0);
        beat("bp_b3", 32'h23, 1'b1, 1'b0);
        done_chk("bp", 16'd1);

        // data wrap
        go(32'hFFFF_FFFE, 16'd4, 16'd1);
        beat("w_b0", 32'hFFFF_FFFE, 1'b0, 1'b1);
        beat("w_b1", 32'hFFFF_FFFF, 1'b0, 1'b0);
        beat("w_b2", 32'h0, 1'b0, 1'b0);
        beat("w_b3", 32'h1, 1'b1, 1'b0);
        done_chk("w", 16'd1);

        // zero length means one-beat packets
        go(32'h5, 16'd0, 16'd2);
        beat("z_b0", 32'h5, 1'b1, 1'b1);
        idle_chk("z_gap0", 1'b1);
        idle_chk("z_gap1", 1'b1);
        beat("z_b1", 32'h6, 1'b1, 1'b1);
        done_chk("z", 16'd2);

        // zero packets: done only
        go(32'h55, 16'd4, 16'd0);
        done_chk("n0", 16'd0);
        chk("n0_idle_vld", 64'(tvalid), 64'(0));

        // reset during beat 2 of 4, then a fresh run
        dest = 4'h3;
        go(32'h40, 16'd4, 16'd1);
        beat("r_b0", 32'h40, 1'b0, 1'b1);
        chk("r_b1_dat", 64'(tdata), 64'(32'h41));
        aresetn = 1'b0;
        #1;
        chk("r_vld", 64'(tvalid), 64'(0));
        chk("r_busy", 64'(busy), 64'(0));
        chk("r_dat", 64'(tdata), 64'(0));
        chk("r_last", 64'(tlast), 64'(0));
        step();
        aresetn = 1'b1;
        step();
        chk("r_idle_vld", 64'(tvalid), 64'(0));
        go(32'h40, 16'd4, 16'd1);
        chk("r2_dest", 64'(tdest), 64'(3));
        beat("r2_b0", 32'h40, 1'b0, 1'b1);
        beat("r2_b1", 32'h41, 1'b0, 1'b0);
        beat("r2_b2", 32'h42, 1'b0, 1'b0);
        beat("r2_b3", 32'h43, 1'b1, 1'b0);
        done_chk("r2", 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
